// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//   Shares one external combinational ALU between two requesters. A
//   round-robin arbiter grants one requester in IDLE. The granted operands
//   are captured and the ALU result is registered in EXEC. The response is
//   then presented in RESP until the consumer accepts it.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   reqN_valid / reqN_ready  request handshake for requester N (N = 0, 1)
//   reqN_a, reqN_b, reqN_op  operands and ALU select (0 add,1 sub,2 and,3 or)
//   alu_a, alu_b, alu_sel    operands driven to the shared ALU
//   alu_out, alu_z           result and zero flag returned by the ALU
//   rsp_valid / rsp_ready    response handshake
//   rsp_id, rsp_data, rsp_z  requester index, result, zero flag
//   op_count                 completed responses, wraps modulo 2^CNT_W
// ---------------------------------------------------------------------------
module alu_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic [1:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    input  logic [1:0]       req1_op,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [1:0]       alu_sel,
    input  logic [31:0]      alu_out,
    input  logic             alu_z,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [31:0]      rsp_data,
    output logic             rsp_z,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_RESP
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_last_grant;
    logic             r_id;
    logic [31:0]      r_a;
    logic [31:0]      r_b;
    logic [1:0]       r_op;
    logic [31:0]      r_rsp_data;
    logic             r_rsp_z;
    logic [CNT_W-1:0] r_count;
    logic             w_grant0;
    logic             w_grant1;
    logic             w_done;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and grants. Readies are gated by rst so they stay low
    // for the whole reset pulse, even though state is already IDLE.
    always_comb begin
        w_next   = r_state;
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        w_done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!rst) begin
                    if (req0_valid && req1_valid) begin
                        // Both contend: favour the one not granted last.
                        w_grant0 = r_last_grant;
                        w_grant1 = !r_last_grant;
                    end else begin
                        w_grant0 = req0_valid;
                        w_grant1 = req1_valid;
                    end
                end
                if (w_grant0 || w_grant1) begin
                    w_next = S_EXEC;
                end
            end
            S_EXEC: begin
                w_next = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_done = 1'b1;
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Datapath: operand capture on grant, result capture in EXEC,
    // completion counting on response handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= 1'b1;
            r_id         <= 1'b0;
            r_a          <= '0;
            r_b          <= '0;
            r_op         <= '0;
            r_rsp_data   <= '0;
            r_rsp_z      <= 1'b0;
            r_count      <= '0;
        end else begin
            if (w_grant0 || w_grant1) begin
                r_a          <= w_grant1 ? req1_a  : req0_a;
                r_b          <= w_grant1 ? req1_b  : req0_b;
                r_op         <= w_grant1 ? req1_op : req0_op;
                r_id         <= w_grant1;
                r_last_grant <= w_grant1;
            end
            if (r_state == S_EXEC) begin
                r_rsp_data <= alu_out;
                r_rsp_z    <= alu_z;
            end
            if (w_done) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;
    assign alu_a      = r_a;
    assign alu_b      = r_b;
    assign alu_sel    = r_op;
    assign rsp_valid  = (r_state == S_RESP);
    assign rsp_id     = r_id;
    assign rsp_data   = r_rsp_data;
    assign rsp_z      = r_rsp_z;
    assign op_count   = r_count;

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
//   Directed scenarios followed by randomized traffic for alu_arbiter.
//   The bench models the shared ALU and keeps a transaction-level reference
//   of the arbiter. It checks every DUT output once per cycle.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req1_valid;
    logic          req0_ready, req1_ready;
    logic [31:0]   req0_a, req0_b, req1_a, req1_b;
    logic [1:0]    req0_op, req1_op;
    logic [31:0]   alu_a, alu_b, alu_out;
    logic [1:0]    alu_sel;
    logic          alu_z;
    logic          rsp_valid, rsp_ready, rsp_id, rsp_z;
    logic [31:0]   rsp_data;
    logic [CW-1:0] op_count;

    int n_vec = 0;
    int n_err = 0;

    alu_arbiter #(.CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_out    (alu_out),
        .alu_z      (alu_z),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_z      (rsp_z),
        .op_count   (op_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [1:0] op);
        case (op)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a & b;
            default: return a | b;
        endcase
    endfunction

    // Shared ALU attached to the DUT
    always_comb begin
        alu_out = alu_fn(alu_a, alu_b, alu_sel);
        alu_z   = (alu_out == 32'd0);
    end

    // Reference model. m_busy counts cycles since grant: 0 idle, 1 computing,
    // 2 response pending.
    int          m_busy;
    int          m_last;
    int          m_count;
    logic [31:0] m_a, m_b, m_data;
    logic [1:0]  m_op;
    logic        m_id, m_z;
    logic        m_g0, m_g1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_last = 1; m_count = 0;
        m_a = '0; m_b = '0; m_op = '0; m_data = '0; m_id = 1'b0; m_z = 1'b0;
        m_g0 = 1'b0; m_g1 = 1'b0;
    endtask

    task automatic check_all(input logic e0, input logic e1);
        chk("req0_ready", 32'(req0_ready), 32'(e0));
        chk("req1_ready", 32'(req1_ready), 32'(e1));
        chk("rsp_valid",  32'(rsp_valid),  32'(m_busy == 2));
        chk("rsp_id",     32'(rsp_id),     32'(m_id));
        chk("rsp_data",   rsp_data,        m_data);
        chk("rsp_z",      32'(rsp_z),      32'(m_z));
        chk("alu_a",      alu_a,           m_a);
        chk("alu_b",      alu_b,           m_b);
        chk("alu_sel",    32'(alu_sel),    32'(m_op));
        chk("op_count",   32'(op_count),   32'(m_count));
    endtask

    // Evaluate one clock cycle with the inputs currently driven.
    // Entered at negedge, returns at the following negedge.
    task automatic cycle();
        int winner;
        #1;
        winner = -1;
        if (m_busy == 0) begin
            if (req0_valid && req1_valid) winner = (m_last == 0) ? 1 : 0;
            else if (req0_valid)          winner = 0;
            else if (req1_valid)          winner = 1;
        end
        check_all(winner == 0, winner == 1);
        m_g0 = (winner == 0);
        m_g1 = (winner == 1);
        if (m_busy == 0) begin
            if (winner >= 0) begin
                m_a    = (winner == 1) ? req1_a  : req0_a;
                m_b    = (winner == 1) ? req1_b  : req0_b;
                m_op   = (winner == 1) ? req1_op : req0_op;
                m_id   = (winner == 1);
                m_last = winner;
                m_busy = 1;
            end
        end else if (m_busy == 1) begin
            m_data = alu_fn(m_a, m_b, m_op);
            m_z    = (m_data == 32'd0);
            m_busy = 2;
        end else if (rsp_ready) begin
            m_count = (m_count + 1) % (1 << CW);
            m_busy  = 0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #1;
        check_all(1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req0_op = '0;
        req1_a = '0; req1_b = '0; req1_op = '0;
        rsp_ready = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Single add from requester 0
        req0_valid = 1'b1; req0_a = 32'd100; req0_b = 32'd60; req0_op = 2'd0;
        rsp_ready = 1'b1;
        cycle();
        req0_valid = 1'b0;
        cycle();
        cycle();
        chk("add_data",  rsp_data, 32'd160);
        chk("add_id",    32'(rsp_id), 32'd0);
        chk("add_z",     32'(rsp_z), 32'd0);
        chk("add_count", 32'(op_count), 32'd1);

        // Simultaneous requests right after reset: requester 0 first
        do_reset();
        req0_valid = 1'b1; req0_a = 32'd10; req0_b = 32'd20; req0_op = 2'd3;
        req1_valid = 1'b1; req1_a = 32'd10; req1_b = 32'd20; req1_op = 2'd2;
        rsp_ready = 1'b1;
        cycle();
        req0_valid = 1'b0;
        cycle();
        chk("rr_first_valid", 32'(rsp_valid), 32'd1);
        chk("rr_first_id",    32'(rsp_id), 32'd0);
        chk("rr_first_data",  rsp_data, 32'd30);
        cycle();
        cycle();
        req1_valid = 1'b0;
        cycle();
        chk("rr_second_id",   32'(rsp_id), 32'd1);
        chk("rr_second_data", rsp_data, 32'd0);
        chk("rr_second_z",    32'(rsp_z), 32'd1);
        cycle();

        // Subtract to zero from requester 1
        req1_valid = 1'b1; req1_a = 32'd20; req1_b = 32'd20; req1_op = 2'd1;
        cycle();
        req1_valid = 1'b0;
        cycle();
        cycle();
        chk("sub_data", rsp_data, 32'd0);
        chk("sub_z",    32'(rsp_z), 32'd1);
        chk("sub_id",   32'(rsp_id), 32'd1);

        // Backpressure in RESP while requester 0 keeps asking
        req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd7; req0_op = 2'd0;
        rsp_ready = 1'b0;
        cycle();
        req0_a = 32'd9; req0_b = 32'd1; req0_op = 2'd1;
        cycle();
        for (int k = 0; k < 3; k++) begin
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_data",  rsp_data, 32'd12);
            chk("bp_id",    32'(rsp_id), 32'd0);
            cycle();
        end
        rsp_ready = 1'b1;
        cycle();
        chk("bp_regrant", 32'(req0_ready), 32'd1);
        cycle();
        req0_valid = 1'b0;
        cycle();
        cycle();
        chk("bp_second_data", rsp_data, 32'd8);

        // Reset during EXEC aborts the operation
        do_reset();
        req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd2; req0_op = 2'd0;
        cycle();
        req0_valid = 1'b0;
        do_reset();
        for (int k = 0; k < 3; k++) cycle();
        chk("abort_count", 32'(op_count), 32'd0);
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("abort_grant0", 32'(req0_ready), 32'd1);
        chk("abort_grant1", 32'(req1_ready), 32'd0);
        cycle();
        req0_valid = 1'b0; req1_valid = 1'b0;
        cycle();
        cycle();

        // Counter wrap with CNT_W=4
        do_reset();
        rsp_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            req0_valid = 1'b1; req0_a = 32'(k); req0_b = 32'd1; req0_op = 2'd0;
            cycle();
            req0_valid = 1'b0;
            cycle();
            cycle();
            if (k == 14) chk("wrap_15", 32'(op_count), 32'd15);
            if (k == 15) chk("wrap_0",  32'(op_count), 32'd0);
        end

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            if (!req0_valid || m_g0) begin
                req0_valid = ($urandom_range(0, 2) != 0);
                req0_a  = $urandom;
                req0_b  = ($urandom_range(0, 3) == 0) ? req0_a : $urandom;
                req0_op = 2'($urandom_range(0, 3));
            end else if ($urandom_range(0, 15) == 0) begin
                req0_valid = 1'b0;
            end
            if (!req1_valid || m_g1) begin
                req1_valid = ($urandom_range(0, 2) != 0);
                req1_a  = $urandom;
                req1_b  = ($urandom_range(0, 3) == 0) ? req1_a : $urandom;
                req1_op = 2'($urandom_range(0, 3));
            end else if ($urandom_range(0, 15) == 0) begin
                req1_valid = 1'b0;
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
